chan_initial_sel: RTL

Channel-side sequencer that performs one parallel-channel initial selection: it presents a device address, runs the address-out/select-out handshake, issues a command byte, and captures the control unit's initial status byte. It drives the "A" channel tag and bus outputs toward a control unit such as the mock CU, and presents a simple start/done interface to an AXI register front end. It owns the bus-out, tag-out and timeout sequencing, so software only supplies an address and a command.

---
 rtl/chan_initial_sel.sv | 288 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/chan_initial_sel.sv
// -----------------------------------------------------------------------------
// chan_initial_sel
//
// Channel-side sequencer for one parallel-channel initial selection. It puts
// a device address on bus-out, runs the address-out / select-out handshake
// with the control unit, sends one command byte, captures the initial status
// byte and then waits for the control unit to drop operational-in.
// Software only supplies an address and a command through start/done.
//
// Parameters
//   SETTLE_CYCLES   cycles bus-out is held stable before address-out or
//                   command-out rises (1..255)
//   TIMEOUT_CYCLES  cycles allowed in any wait state before giving up (16-bit)
//
// Ports
//   aclk, aresetn          clock, asynchronous active-low reset
//   enable                 channel enable (also drives a_operational_out)
//   start, dev_addr, cmd   request strobe with its address / command bytes
//   busy, done             transaction in progress / one-cycle completion
//   result                 0 OK, 1 NO_DEVICE, 2 ADDR_MISMATCH, 3 TIMEOUT,
//                          4 ABORTED; held until the next start
//   unit_status            status byte from the control unit
//   a_*_out / a_*_in       "A" channel bus and tag lines
// -----------------------------------------------------------------------------
module chan_initial_sel #(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       enable,
  input  logic       start,
  input  logic [7:0] dev_addr,
  input  logic [7:0] cmd,
  output logic       busy,
  output logic       done,
  output logic [2:0] result,
  output logic [7:0] unit_status,
  output logic [7:0] a_bus_out,
  input  logic [7:0] a_bus_in,
  output logic       a_operational_out,
  output logic       a_hold_out,
  output logic       a_select_out,
  output logic       a_address_out,
  output logic       a_command_out,
  output logic       a_service_out,
  output logic       a_suppress_out,
  input  logic       a_operational_in,
  input  logic       a_request_in,
  input  logic       a_select_in,
  input  logic       a_address_in,
  input  logic       a_status_in,
  input  logic       a_service_in
);

  localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] RES_OK       = 3'd0;
  localparam logic [2:0] RES_NODEV    = 3'd1;
  localparam logic [2:0] RES_MISMATCH = 3'd2;
  localparam logic [2:0] RES_TIMEOUT  = 3'd3;
  localparam logic [2:0] RES_ABORTED  = 3'd4;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_ADDR_SETUP  = 4'd1,
    ST_WAIT_ADDR   = 4'd2,
    ST_CMD_SETUP   = 4'd3,
    ST_CMD_OUT     = 4'd4,
    ST_WAIT_STATUS = 4'd5,
    ST_ACCEPT      = 4'd6,
    ST_CLEANUP     = 4'd7,
    ST_DONE        = 4'd8
  } state_t;

  state_t      state_q,    state_d;
  logic [15:0] cnt_q,      cnt_d;
  logic [7:0]  addr_q,     addr_d;
  logic [7:0]  cmd_q,      cmd_d;
  logic        busy_q,     busy_d;
  logic        done_q,     done_d;
  logic [2:0]  result_q,   result_d;
  logic [7:0]  status_q,   status_d;
  logic [7:0]  bus_q,      bus_d;
  logic        oper_q,     oper_d;
  logic        select_q,   select_d;
  logic        address_q,  address_d;
  logic        command_q,  command_d;
  logic        service_q,  service_d;

  // Request-in and service-in play no part in an initial selection.
  logic unused_inputs;
  assign unused_inputs = a_request_in ^ a_service_in;

  logic timeout_hit;
  assign timeout_hit = (cnt_q == TIMEOUT_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 16'd1;
    addr_d    = addr_q;
    cmd_d     = cmd_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
    status_d  = status_q;
    bus_d     = bus_q;
    oper_d    = enable;
    select_d  = select_q;
    address_d = address_q;
    command_d = command_q;
    service_d = service_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        if (start && enable) begin
          addr_d   = dev_addr;
          cmd_d    = cmd;
          bus_d    = dev_addr;
          result_d = RES_OK;
          status_d = 8'h00;
          busy_d   = 1'b1;
          state_d  = ST_ADDR_SETUP;
        end
      end

      ST_ADDR_SETUP: begin
        if (cnt_q == SETTLE_LAST) begin
          address_d = 1'b1;
          select_d  = 1'b1;
          state_d   = ST_WAIT_ADDR;
        end
      end

      ST_WAIT_ADDR: begin
        // Select-in coming back means nobody claimed the address; it wins
        // over a simultaneous address-in.
        if (a_select_in) begin
          result_d = RES_NODEV;
          state_d  = ST_CLEANUP;
        end else if (a_operational_in && a_address_in) begin
          if (a_bus_in != addr_q) begin
            result_d = RES_MISMATCH;
            state_d  = ST_CLEANUP;
          end else begin
            address_d = 1'b0;
            bus_d     = cmd_q;
            state_d   = ST_CMD_SETUP;
          end
        end else if (timeout_hit) begin
          result_d = RES_TIMEOUT;
          state_d  = ST_CLEANUP;
        end
      end

      ST_CMD_SETUP: begin
        if (cnt_q == SETTLE_LAST) begin
          command_d = 1'b1;
          state_d   = ST_CMD_OUT;
        end
      end

      ST_CMD_OUT: begin
        if (!a_address_in) begin
          command_d = 1'b0;
          bus_d     = 8'h00;
          state_d   = ST_WAIT_STATUS;
        end else if (timeout_hit) begin
          result_d = RES_TIMEOUT;
          state_d  = ST_CLEANUP;
        end
      end

      ST_WAIT_STATUS: begin
        if (a_status_in) begin
          status_d  = a_bus_in;
          service_d = 1'b1;
          state_d   = ST_ACCEPT;
        end else if (timeout_hit) begin
          result_d = RES_TIMEOUT;
          state_d  = ST_CLEANUP;
        end
      end

      ST_ACCEPT: begin
        if (!a_status_in) begin
          service_d = 1'b0;
          result_d  = RES_OK;
          state_d   = ST_CLEANUP;
        end else if (timeout_hit) begin
          result_d = RES_TIMEOUT;
          state_d  = ST_CLEANUP;
        end
      end

      ST_CLEANUP: begin
        if (!a_operational_in) begin
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          result_d = RES_TIMEOUT;
          state_d  = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Losing the channel enable mid-transaction skips the operational-in
    // wait entirely.
    if (!enable && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
      result_d = RES_ABORTED;
      state_d  = ST_DONE;
    end

    // Tags and bus-out are released on the very edge that enters cleanup
    // or done, so the control unit sees them drop one cycle after its cue.
    if ((state_d == ST_CLEANUP) || (state_d == ST_DONE)) begin
      select_d  = 1'b0;
      address_d = 1'b0;
      command_d = 1'b0;
      service_d = 1'b0;
      bus_d     = 8'h00;
    end

    if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      done_d = 1'b1;
      busy_d = 1'b0;
    end

    // Counter restarts on every state entry and is meaningless at rest.
    if ((state_d != state_q) || (state_q == ST_IDLE)) begin
      cnt_d = 16'd0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 16'd0;
      addr_q    <= 8'h00;
      cmd_q     <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= 3'd0;
      status_q  <= 8'h00;
      bus_q     <= 8'h00;
      oper_q    <= 1'b0;
      select_q  <= 1'b0;
      address_q <= 1'b0;
      command_q <= 1'b0;
      service_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      cmd_q     <= cmd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      status_q  <= status_d;
      bus_q     <= bus_d;
      oper_q    <= oper_d;
      select_q  <= select_d;
      address_q <= address_d;
      command_q <= command_d;
      service_q <= service_d;
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign result            = result_q;
  assign unit_status       = status_q;
  assign a_bus_out         = bus_q;
  assign a_operational_out = oper_q;
  assign a_select_out      = select_q;
  assign a_hold_out        = select_q;
  assign a_address_out     = address_q;
  assign a_command_out     = command_q;
  assign a_service_out     = service_q;
  assign a_suppress_out    = 1'b0;

endmodule
